inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 74 +++++++
 tb/tb_inst_fetch_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: single-outstanding instruction fetch sequencer with decoder handshake and flush redirect
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  input  logic        dec_stall,
  input  logic [31:0] dec_next_pc,
  input  logic        rob_clear,
  input  logic [31:0] rob_clear_pc,
  output logic [31:0] fetch_cnt
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, FLUSH = 2'd3;
  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] tgt;
  // next fetch target: redirect wins, then decoder (only meaningful in HOLD), else current pc
  always_comb tgt = rob_clear ? rob_clear_pc : (state == HOLD ? dec_next_pc : pc);
  assign mem_req = (state == FETCH) || (state == FLUSH);
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      mem_addr   <= 32'h0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      inst_addr  <= 32'h0;
      fetch_cnt  <= 32'h0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          pc       <= tgt;
          mem_addr <= {tgt[31:2], 2'b00};
          state    <= FETCH;
        end
        FETCH: begin
          if (rob_clear) pc <= rob_clear_pc;
          if (mem_done && rob_clear) mem_addr <= {tgt[31:2], 2'b00};
          if (mem_done && !rob_clear) begin
            inst       <= mem_data;
            inst_addr  <= pc;
            inst_valid <= 1'b1;
          end
          state <= rob_clear ? (mem_done ? FETCH : FLUSH) : (mem_done ? HOLD : FETCH);
        end
        HOLD: begin
          if (rob_clear || !dec_stall) begin
            pc         <= tgt;
            mem_addr   <= {tgt[31:2], 2'b00};
            inst_valid <= 1'b0;
            fetch_cnt  <= rob_clear ? fetch_cnt : fetch_cnt + 32'd1;
            state      <= FETCH;
          end
        end
        default: begin
          // old request stays on the bus until memory answers; its data is dropped
          if (rob_clear) pc <= rob_clear_pc;
          if (mem_done) begin
            mem_addr <= {tgt[31:2], 2'b00};
            state    <= FETCH;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed pins plus randomized traffic checked every cycle against a behavioural fetch model
module tb_inst_fetch_ctrl;
  logic        clk_in, rst_in, rdy_in, mem_req, mem_done, inst_valid, dec_stall, rob_clear;
  logic [31:0] mem_addr, mem_data, inst, inst_addr, dec_next_pc, rob_clear_pc, fetch_cnt;
  int tests = 0;
  int fails = 0;
  logic [31:0] cnt_off = 32'h0;
  logic        m_idle, m_req, m_disc, m_vld;
  logic [31:0] m_pc, m_addr, m_inst, m_iaddr, m_acc;

  inst_fetch_ctrl #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr),
    .dec_stall(dec_stall), .dec_next_pc(dec_next_pc),
    .rob_clear(rob_clear), .rob_clear_pc(rob_clear_pc), .fetch_cnt(fetch_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: is a request outstanding, is its answer to be dropped, is an instruction on offer
  always @(posedge clk_in or negedge rst_in) begin : model
    logic idle, req, disc, vld;
    logic [31:0] pc, addr, ins, iaddr, acc;
    if (!rst_in) begin
      m_idle <= 1'b1; m_req <= 1'b0; m_disc <= 1'b0; m_vld <= 1'b0;
      m_pc <= 32'h0; m_addr <= 32'h0; m_inst <= 32'h0; m_iaddr <= 32'h0; m_acc <= 32'h0;
    end else begin
      idle = m_idle; req = m_req; disc = m_disc; vld = m_vld;
      pc = m_pc; addr = m_addr; ins = m_inst; iaddr = m_iaddr; acc = m_acc;
      if (rdy_in) begin
        if (idle) begin
          idle = 1'b0;
          if (rob_clear) pc = rob_clear_pc;
          req = 1'b1;
          addr = pc & ~32'h3;
        end else if (req) begin
          if (mem_done) begin
            if (rob_clear) pc = rob_clear_pc;
            if (rob_clear || disc) begin
              addr = pc & ~32'h3;
              disc = 1'b0;
            end else begin
              vld = 1'b1; ins = mem_data; iaddr = pc; req = 1'b0;
            end
          end else if (rob_clear) begin
            pc = rob_clear_pc;
            disc = 1'b1;
          end
        end else if (rob_clear || !dec_stall) begin
          if (!rob_clear) acc = acc + 32'd1;
          pc = rob_clear ? rob_clear_pc : dec_next_pc;
          vld = 1'b0; req = 1'b1;
          addr = pc & ~32'h3;
        end
      end
      m_idle <= idle; m_req <= req; m_disc <= disc; m_vld <= vld;
      m_pc <= pc; m_addr <= addr; m_inst <= ins; m_iaddr <= iaddr; m_acc <= acc;
    end
  end

  always @(negedge clk_in) begin
    chk("mem_req", {31'h0, mem_req}, {31'h0, m_req});
    chk("mem_addr", mem_addr, m_addr);
    chk("inst_valid", {31'h0, inst_valid}, {31'h0, m_vld});
    chk("inst", inst, m_inst);
    chk("inst_addr", inst_addr, m_iaddr);
    chk("fetch_cnt", fetch_cnt, m_acc + cnt_off);
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  initial begin
    logic [31:0] held;
    logic prev_done;
    rst_in = 1'b0; rdy_in = 1'b1; mem_done = 1'b0; mem_data = 32'h0; dec_stall = 1'b1;
    dec_next_pc = 32'h0; rob_clear = 1'b0; rob_clear_pc = 32'h0;
    tick(); tick();
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    rst_in = 1'b1;
    tick();
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", mem_addr, 32'h0);
    tick(); tick();
    mem_done = 1'b1; mem_data = 32'h00500093;
    tick();
    mem_done = 1'b0;
    chk("first_valid", {31'h0, inst_valid}, 32'h1);
    chk("first_inst", inst, 32'h00500093);
    chk("first_iaddr", inst_addr, 32'h0);
    chk("req_dropped", {31'h0, mem_req}, 32'h0);
    dec_next_pc = 32'h8;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_inst", inst, 32'h00500093);
      chk("stall_valid", {31'h0, inst_valid}, 32'h1);
    end
    dec_stall = 1'b0;
    tick();
    dec_stall = 1'b1;
    chk("acc_addr", mem_addr, 32'h8);
    chk("acc_cnt", fetch_cnt, 32'h1);
    chk("acc_valid", {31'h0, inst_valid}, 32'h0);
    mem_done = 1'b1; mem_data = 32'h11111111;
    tick();
    mem_done = 1'b0; dec_stall = 1'b0; dec_next_pc = 32'h10;
    tick();
    dec_stall = 1'b1;
    chk("fetch10_addr", mem_addr, 32'h10);
    rob_clear = 1'b1; rob_clear_pc = 32'h40;
    tick();
    rob_clear = 1'b0;
    chk("flush_addr_held", mem_addr, 32'h10);
    chk("flush_req", {31'h0, mem_req}, 32'h1);
    tick();
    mem_done = 1'b1; mem_data = 32'hDEADBEEF;
    tick();
    mem_done = 1'b0;
    chk("flush_valid", {31'h0, inst_valid}, 32'h0);
    chk("flush_redirect", mem_addr, 32'h40);
    chk("flush_req2", {31'h0, mem_req}, 32'h1);
    mem_done = 1'b1; mem_data = 32'h00000013;
    tick();
    mem_done = 1'b0; dec_stall = 1'b0; dec_next_pc = 32'h200;
    rob_clear = 1'b1; rob_clear_pc = 32'h100;
    tick();
    rob_clear = 1'b0; dec_stall = 1'b1;
    chk("clr_acc_cnt", fetch_cnt, 32'h2);
    chk("clr_acc_addr", mem_addr, 32'h100);
    mem_done = 1'b1; mem_data = 32'h00A00113;
    tick();
    mem_done = 1'b0; dec_stall = 1'b0; dec_next_pc = 32'h20; rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_valid", {31'h0, inst_valid}, 32'h1);
      chk("frz_inst", inst, 32'h00A00113);
      chk("frz_cnt", fetch_cnt, 32'h2);
    end
    rdy_in = 1'b1;
    tick();
    dec_stall = 1'b1;
    chk("thaw_cnt", fetch_cnt, 32'h3);
    chk("thaw_addr", mem_addr, 32'h20);
    force dut.fetch_cnt = 32'hFFFFFFFF;
    cnt_off = 32'hFFFFFFFF - m_acc;
    #1;
    release dut.fetch_cnt;
    mem_done = 1'b1; mem_data = 32'h1;
    tick();
    mem_done = 1'b0; dec_stall = 1'b0; dec_next_pc = 32'h0;
    tick();
    dec_stall = 1'b1;
    chk("wrap0", fetch_cnt, 32'h0);
    mem_done = 1'b1; mem_data = 32'h2;
    tick();
    mem_done = 1'b0; dec_stall = 1'b0; dec_next_pc = 32'h13;
    tick();
    dec_stall = 1'b1;
    chk("wrap1", fetch_cnt, 32'h1);
    chk("align_addr", mem_addr, 32'h10);
    prev_done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!rst_in) rst_in = 1'b1;
      else if ($urandom_range(0, 499) == 0) begin
        rst_in = 1'b0;
        cnt_off = 32'h0;
      end
      rdy_in = ($urandom_range(0, 7) != 0);
      rob_clear = ($urandom_range(0, 15) == 0);
      rob_clear_pc = $urandom;
      dec_stall = ($urandom_range(0, 2) == 0);
      dec_next_pc = $urandom;
      mem_data = $urandom;
      held = $urandom;
      mem_done = !prev_done && (mem_req ? held[1:0] == 2'd0 : held[6:2] == 5'd0);
      prev_done = mem_done;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
